// File: rtl/frame_rr_arb.sv
// frame_rr_arb: frame-aware round-robin scheduler sharing one host byte transport
// between N byte-stream clients.
//
// TX: one client owns the transport for a whole frame (header H plus H[3:0] payload
//     bytes). Clients are picked round-robin from rr_ptr upward.
// RX: each incoming frame goes to the client named by H[7:6]. Frames addressed to
//     an absent client are popped and discarded, and counted in rx_drop.
//
// Ports:
//   CLK, RESET          single clock, synchronous active-high reset
//   c_tx_rdempty/rddata client TX FIFOs (show-ahead), c_tx_rden pops them
//   c_rx_wrfull         client RX FIFO full flags, c_rx_wren/c_rx_wrdata push them
//   com_wrfull          transport TX FIFO full, com_wren/com_wrdata push it
//   com_rdempty/rddata  transport RX FIFO (show-ahead), com_rden pops it
//   tx_grant            current or last granted TX client
//   tx_busy             TX frame in progress
//   rx_drop             saturating count of discarded RX frames
module frame_rr_arb #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N-1:0]    c_tx_rdempty,
  input  logic [DW*N-1:0] c_tx_rddata,
  output logic [N-1:0]    c_tx_rden,
  input  logic [N-1:0]    c_rx_wrfull,
  output logic [N-1:0]    c_rx_wren,
  output logic [DW-1:0]   c_rx_wrdata,
  input  logic            com_wrfull,
  output logic            com_wren,
  output logic [DW-1:0]   com_wrdata,
  input  logic            com_rdempty,
  input  logic [DW-1:0]   com_rddata,
  output logic            com_rden,
  output logic [1:0]      tx_grant,
  output logic            tx_busy,
  output logic [7:0]      rx_drop
);

  typedef enum logic [1:0] {TIdle, THdr, TPay} tx_st_e;
  typedef enum logic {RHdr, RPay} rx_st_e;

  tx_st_e      tx_st_q, tx_st_d;
  logic [1:0]  tx_grant_q, tx_grant_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d;
  logic        tx_busy_q, tx_busy_d;

  rx_st_e      rx_st_q, rx_st_d;
  logic [1:0]  rx_dest_q, rx_dest_d;
  logic        rx_discard_q, rx_discard_d;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_drop_q, rx_drop_d;

  // ---------------------------------------------------------------------------
  // TX arbitration and byte movement
  // ---------------------------------------------------------------------------
  logic          arb_found;
  logic [1:0]    arb_pick;
  logic [1:0]    arb_cand;
  logic [1:0]    rr_next;
  logic          gnt_empty;
  logic [DW-1:0] gnt_byte;
  logic          tx_move;

  // First requester at or above rr_ptr, wrapping modulo N.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_cand  = '0;
    for (int k = 0; k < int'(N); k++) begin
      arb_cand = 2'((int'(rr_ptr_q) + k) % int'(N));
      for (int i = 0; i < int'(N); i++) begin
        if (!arb_found && (arb_cand == 2'(i)) && !c_tx_rdempty[i]) begin
          arb_found = 1'b1;
          arb_pick  = arb_cand;
        end
      end
    end
  end

  assign rr_next = (arb_pick == 2'(N - 1)) ? 2'd0 : arb_pick + 2'd1;

  // Granted client's FIFO view.
  always_comb begin
    gnt_empty = 1'b1;
    gnt_byte  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (tx_grant_q == 2'(i)) begin
        gnt_empty = c_tx_rdempty[i];
        gnt_byte  = c_tx_rddata[DW*i +: DW];
      end
    end
  end

  // Strobes are suppressed in the reset cycle so an aborted frame loses no byte.
  assign tx_move = !RESET && (tx_st_q != TIdle) && !gnt_empty && !com_wrfull;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      c_tx_rden[i] = tx_move && (tx_grant_q == 2'(i));
    end
  end

  assign com_wren   = tx_move;
  assign com_wrdata = tx_move ? gnt_byte : '0;

  always_comb begin
    tx_st_d    = tx_st_q;
    tx_grant_d = tx_grant_q;
    rr_ptr_d   = rr_ptr_q;
    tx_cnt_d   = tx_cnt_q;
    case (tx_st_q)
      TIdle: begin
        if (arb_found) begin
          tx_grant_d = arb_pick;
          rr_ptr_d   = rr_next;
          tx_st_d    = THdr;
        end
      end
      THdr: begin
        if (tx_move) begin
          tx_cnt_d = gnt_byte[3:0];
          tx_st_d  = (gnt_byte[3:0] == 4'd0) ? TIdle : TPay;
        end
      end
      TPay: begin
        if (tx_move) begin
          tx_cnt_d = tx_cnt_q - 4'd1;
          if (tx_cnt_q == 4'd1) begin
            tx_st_d = TIdle;
          end
        end
      end
      default: tx_st_d = TIdle;
    endcase
    tx_busy_d = (tx_st_d != TIdle);
  end

  // ---------------------------------------------------------------------------
  // RX routing
  // ---------------------------------------------------------------------------
  logic [1:0] rx_dest_cur;
  logic       rx_disc_cur;
  logic       rx_dest_full;
  logic       rx_accept;
  logic       rx_push;

  // At the header the destination comes straight from the byte; afterwards it is latched.
  assign rx_dest_cur = (rx_st_q == RHdr) ? com_rddata[7:6] : rx_dest_q;
  assign rx_disc_cur = (rx_st_q == RHdr) ? (32'(com_rddata[7:6]) >= N) : rx_discard_q;

  always_comb begin
    rx_dest_full = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      if (rx_dest_cur == 2'(i)) begin
        rx_dest_full = c_rx_wrfull[i];
      end
    end
  end

  assign rx_accept = !RESET && !com_rdempty && (rx_disc_cur || !rx_dest_full);
  assign rx_push   = rx_accept && !rx_disc_cur;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      c_rx_wren[i] = rx_push && (rx_dest_cur == 2'(i));
    end
  end

  assign com_rden    = rx_accept;
  assign c_rx_wrdata = rx_push ? com_rddata : '0;

  always_comb begin
    rx_st_d      = rx_st_q;
    rx_dest_d    = rx_dest_q;
    rx_discard_d = rx_discard_q;
    rx_cnt_d     = rx_cnt_q;
    rx_drop_d    = rx_drop_q;
    case (rx_st_q)
      RHdr: begin
        if (rx_accept) begin
          rx_dest_d    = rx_dest_cur;
          rx_discard_d = rx_disc_cur;
          rx_cnt_d     = com_rddata[3:0];
          if (rx_disc_cur && (rx_drop_q != 8'hFF)) begin
            rx_drop_d = rx_drop_q + 8'd1;
          end
          if (com_rddata[3:0] != 4'd0) begin
            rx_st_d = RPay;
          end
        end
      end
      RPay: begin
        if (rx_accept) begin
          rx_cnt_d = rx_cnt_q - 4'd1;
          if (rx_cnt_q == 4'd1) begin
            rx_st_d = RHdr;
          end
        end
      end
      default: rx_st_d = RHdr;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_st_q      <= TIdle;
      tx_grant_q   <= 2'd0;
      rr_ptr_q     <= 2'd0;
      tx_cnt_q     <= 4'd0;
      tx_busy_q    <= 1'b0;
      rx_st_q      <= RHdr;
      rx_dest_q    <= 2'd0;
      rx_discard_q <= 1'b0;
      rx_cnt_q     <= 4'd0;
      rx_drop_q    <= 8'd0;
    end else begin
      tx_st_q      <= tx_st_d;
      tx_grant_q   <= tx_grant_d;
      rr_ptr_q     <= rr_ptr_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_busy_q    <= tx_busy_d;
      rx_st_q      <= rx_st_d;
      rx_dest_q    <= rx_dest_d;
      rx_discard_q <= rx_discard_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_drop_q    <= rx_drop_d;
    end
  end

  assign tx_grant = tx_grant_q;
  assign tx_busy  = tx_busy_q;
  assign rx_drop  = rx_drop_q;

endmodule
